buzzer_tone_sequencer: RTL and testbench

Sequencer and arbiter for the game's single piezo buzzer. Hit, miss and countdown logic each post one-cycle tone requests. The block queues them as sticky pending bits and grants the buzzer to one requester at a time by fixed priority. For each grant it plays a square wave of that requester's half-period for that requester's duration, then inserts a silent gap. It sits between the game-state logic and the buzzer pin.

---
 rtl/buzzer_pkg.sv | 28 ++
 rtl/buzzer_prio_enc.sv | 35 +++
 rtl/buzzer_tone_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_buzzer_tone_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer tone sequencer.
// Holds the sequencer state enum, default field widths, the default
// post-tone gap and the half-period constants of the game tones.
package buzzer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } buz_state_e;

   localparam int BUZ_HALF_W  = 17;
   localparam int BUZ_DUR_W   = 24;
   localparam int BUZ_GAP_CYC = 1000;

   // Board clock the tone constants are derived from.
   localparam int BUZ_CLK_HZ = 50_000_000;

   // Half-period in clock cycles for a square wave of the given frequency.
   function automatic int half_for_hz(input int hz);
      return BUZ_CLK_HZ / (2 * hz);
   endfunction

   localparam logic [BUZ_HALF_W-1:0] HALF_HIT       = BUZ_HALF_W'(half_for_hz(2000)); // 2 kHz
   localparam logic [BUZ_HALF_W-1:0] HALF_MISS      = BUZ_HALF_W'(half_for_hz(500));  // 500 Hz
   localparam logic [BUZ_HALF_W-1:0] HALF_COUNTDOWN = BUZ_HALF_W'(half_for_hz(1000)); // 1 kHz

endpackage

// File: rtl/buzzer_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot of the lowest set bit,
// its binary index, and an any-set flag. Purely combinational.
module buzzer_prio_enc
   import buzzer_pkg::*;
#(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_vec,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // seen[i] is set when some bit below i is already set
   logic [N:0] seen;

   assign seen[0] = 1'b0;

   for (genvar gi = 0; gi < N; gi++) begin : g_chain
      assign onehot[gi]   = req_vec[gi] & ~seen[gi];
      assign seen[gi + 1] = seen[gi] | req_vec[gi];
   end

   assign any = seen[N];

   // Binary index of the single one-hot bit (zero when nothing is set)
   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (onehot[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/buzzer_tone_sequencer.sv
// Buzzer tone sequencer / arbiter. Requests are held as sticky pending
// bits, granted lowest index first; each grant plays a square wave of
// the latched half-period for the latched duration, then a silent gap.
// Optional feature: define BUZZER_PREEMPT_EN to let a higher-priority
// pending request abort the tone currently playing.
module buzzer_tone_sequencer
   import buzzer_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int HALF_W  = BUZ_HALF_W,
   parameter int DUR_W   = BUZ_DUR_W,
   parameter int GAP_CYC = BUZ_GAP_CYC
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*HALF_W-1:0] tone_half,
   input  logic [NUM_REQ*DUR_W-1:0]  tone_dur,
   output logic                      buzzer,
   output logic                      busy,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      done
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

   buz_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  pend_q, pend_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [HALF_W-1:0]   half_q, half_d;
   logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
   logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic                buzzer_q, buzzer_d;
   logic                done_q, done_d;

   logic [NUM_REQ-1:0]  enc_onehot;
   logic [IDX_W-1:0]    enc_idx;
   logic                enc_any;
   logic [NUM_REQ-1:0]  pend_clr;
   logic                load;
   logic                preempt;
   logic [HALF_W-1:0]   sel_half;
   logic [DUR_W-1:0]    sel_dur;

   buzzer_prio_enc #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .req_vec (pend_q),
      .onehot  (enc_onehot),
      .idx     (enc_idx),
      .any     (enc_any)
   );

   assign sel_half = tone_half[enc_idx * HALF_W +: HALF_W];
   assign sel_dur  = tone_dur[enc_idx * DUR_W +: DUR_W];

`ifdef BUZZER_PREEMPT_EN
   // Both vectors are one-hot, so a smaller value means a lower index.
   assign preempt = enc_any && (enc_onehot < grant_q);
`else
   assign preempt = 1'b0;
`endif

   // Next-state, counters and output drive for the IDLE/PLAY/GAP sequencer
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      half_d     = half_q;
      half_cnt_d = half_cnt_q;
      dur_cnt_d  = dur_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      buzzer_d   = buzzer_q;
      done_d     = 1'b0;
      pend_clr   = '0;
      load       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            load = enc_any;
         end

         ST_PLAY: begin
            if (preempt) begin
               // aborted tone: no done pulse, no gap, not re-queued
               load = 1'b1;
            end else begin
               // half=0 is a rest: counter and buzzer stay idle
               if (half_q != '0) begin
                  if (half_cnt_q == half_q - HALF_W'(1)) begin
                     buzzer_d   = ~buzzer_q;
                     half_cnt_d = '0;
                  end else begin
                     half_cnt_d = half_cnt_q + HALF_W'(1);
                  end
               end
               dur_cnt_d = dur_cnt_q - DUR_W'(1);
               if (dur_cnt_q <= DUR_W'(1)) begin
                  done_d     = 1'b1;
                  buzzer_d   = 1'b0;
                  grant_d    = '0;
                  half_cnt_d = '0;
                  dur_cnt_d  = '0;
                  if (GAP_CYC == 0) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d   = ST_GAP;
                     gap_cnt_d = GAP_W'(GAP_CYC);
                  end
               end
            end
         end

         ST_GAP: begin
            if (gap_cnt_q <= GAP_W'(1)) begin
               gap_cnt_d = '0;
               // back-to-back: go straight to the next tone when one is queued
               if (enc_any) load = 1'b1;
               else         state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Grant the lowest pending requester and latch its tone parameters
      if (load) begin
         pend_clr   = enc_onehot;
         half_d     = sel_half;
         half_cnt_d = '0;
         buzzer_d   = 1'b0;
         if (sel_dur == '0) begin
            // zero-length tone skips PLAY entirely but still reports done
            grant_d   = '0;
            dur_cnt_d = '0;
            done_d    = 1'b1;
            if (GAP_CYC == 0) begin
               state_d = ST_IDLE;
            end else begin
               state_d   = ST_GAP;
               gap_cnt_d = GAP_W'(GAP_CYC);
            end
         end else begin
            state_d   = ST_PLAY;
            grant_d   = enc_onehot;
            dur_cnt_d = sel_dur;
         end
      end

      // a new request beats a same-cycle grant clear, so it is queued again
      pend_d = (pend_q & ~pend_clr) | req;
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pend_q     <= '0;
         grant_q    <= '0;
         half_q     <= '0;
         half_cnt_q <= '0;
         dur_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         buzzer_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         grant_q    <= grant_d;
         half_q     <= half_d;
         half_cnt_q <= half_cnt_d;
         dur_cnt_q  <= dur_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         buzzer_q   <= buzzer_d;
         done_q     <= done_d;
      end
   end

   assign buzzer = buzzer_q;
   assign busy   = (state_q != ST_IDLE);
   assign grant  = grant_q;
   assign done   = done_q;

endmodule

// File: tb/tb_buzzer_tone_sequencer.sv
// Scoreboard bench for buzzer_tone_sequencer (GAP_CYC=3, 8-bit fields).
// Stimulus pushes expected output events (grant start/end, buzzer rise,
// done, busy falling) with their cycle numbers; a negedge monitor pops
// and compares them. The preempt scenario expects the behaviour matching
// whether BUZZER_PREEMPT_EN is defined.
module tb_buzzer_tone_sequencer;

   localparam int NR = 3;
   localparam int HW = 8;
   localparam int DW = 8;
   localparam int GC = 3;

   localparam int EV_GRANT = 0;
   localparam int EV_GEND  = 1;
   localparam int EV_RISE  = 2;
   localparam int EV_DONE  = 3;
   localparam int EV_IDLE  = 4;

   typedef struct {
      int         kind;
      logic [2:0] val;
      int         cyc;
   } ev_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req;
   logic [NR*HW-1:0] tone_half;
   logic [NR*DW-1:0] tone_dur;
   logic             buzzer;
   logic             busy;
   logic [NR-1:0]    grant;
   logic             done;

   ev_t exp_q[$];
   int  cyc = 0;
   int  n_total = 0;
   int  n_pass = 0;
   bit  mon_en = 1'b0;
   logic [NR-1:0] prev_grant = '0;
   logic          prev_buz = 1'b0;
   logic          prev_busy = 1'b0;

   buzzer_tone_sequencer #(
      .NUM_REQ (NR),
      .HALF_W  (HW),
      .DUR_W   (DW),
      .GAP_CYC (GC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .tone_half (tone_half),
      .tone_dur  (tone_dur),
      .buzzer    (buzzer),
      .busy      (busy),
      .grant     (grant),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         EV_GRANT: return "grant";
         EV_GEND:  return "grant_end";
         EV_RISE:  return "buzzer_rise";
         EV_DONE:  return "done";
         EV_IDLE:  return "busy_fall";
         default:  return "unknown";
      endcase
   endfunction

   task automatic push(input int kind, input logic [2:0] val, input int c);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input logic [2:0] val);
      ev_t e;
      n_total++;
      if (exp_q.size() == 0) begin
         $display("FAIL unexpected_event: got %s val=%b cyc=%0d, required no event", kname(kind), val, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind == kind && e.val == val && e.cyc == cyc) begin
            n_pass++;
            $display("ok   %s val=%b cyc=%0d", kname(kind), val, cyc);
         end else begin
            $display("FAIL event: got %s val=%b cyc=%0d, required %s val=%b cyc=%0d",
                     kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_total++;
      if (act === exp_v) begin
         n_pass++;
         $display("ok   %s = %0d", name, act);
      end else begin
         $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
      end
   endtask

   // Monitor: turn output changes into events and score them in order
   always @(negedge clk) begin
      if (mon_en) begin
         if (grant != '0 && grant != prev_grant) observe(EV_GRANT, grant);
         if (grant == '0 && prev_grant != '0)    observe(EV_GEND, 3'b000);
         if (buzzer && !prev_buz)                observe(EV_RISE, 3'b000);
         if (done)                               observe(EV_DONE, 3'b000);
         if (!busy && prev_busy)                 observe(EV_IDLE, 3'b000);
      end
      prev_grant <= grant;
      prev_buz   <= buzzer;
      prev_busy  <= busy;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic drive_req(input logic [NR-1:0] mask, input int hold);
      req = mask;
      step(hold);
      req = '0;
   endtask

   task automatic set_tone(input int i, input int h, input int d);
      tone_half[i*HW +: HW] = h[HW-1:0];
      tone_dur[i*DW +: DW]  = d[DW-1:0];
   endtask

   int k;
   int s;
   int s1;

   initial begin
      rst       = 1'b1;
      req       = '0;
      tone_half = '0;
      tone_dur  = '0;
      step(3);
      chk("reset_buzzer", 32'(buzzer), 32'd0);
      chk("reset_busy",   32'(busy),   32'd0);
      chk("reset_grant",  32'(grant),  32'd0);
      chk("reset_done",   32'(done),   32'd0);
      rst = 1'b0;
      step(2);
      mon_en = 1'b1;

      // Single tone on req[1]: half=4, dur=20; inputs changed after latch
      set_tone(1, 4, 20);
      k = cyc; s = k + 2;
      push(EV_GRANT, 3'b010, s);
      push(EV_RISE,  3'b000, s + 4);
      push(EV_RISE,  3'b000, s + 12);
      push(EV_GEND,  3'b000, s + 20);
      push(EV_DONE,  3'b000, s + 20);
      push(EV_IDLE,  3'b000, s + 23);
      drive_req(3'b010, 1);
      step(2);
      set_tone(1, 2, 5);
      wait_until(s + 30);

      // Reset in the middle of PLAY with req[2] queued
      set_tone(1, 4, 20);
      k = cyc; s = k + 2;
      push(EV_GRANT, 3'b010, s);
      push(EV_RISE,  3'b000, s + 4);
      push(EV_GEND,  3'b000, s + 7);
      push(EV_IDLE,  3'b000, s + 7);
      drive_req(3'b010, 1);
      wait_until(s + 5);
      drive_req(3'b100, 1);
      rst = 1'b1;
      step(1);
      chk("midplay_rst_buzzer", 32'(buzzer), 32'd0);
      chk("midplay_rst_busy",   32'(busy),   32'd0);
      chk("midplay_rst_grant",  32'(grant),  32'd0);
      rst = 1'b0;
      wait_until(s + 22);

      // Simultaneous req[0] and req[2]
      set_tone(0, 2, 6);
      set_tone(2, 3, 7);
      k = cyc; s = k + 2; s1 = s + 9;
      push(EV_GRANT, 3'b001, s);
      push(EV_RISE,  3'b000, s + 2);
      push(EV_GEND,  3'b000, s + 6);
      push(EV_DONE,  3'b000, s + 6);
      push(EV_GRANT, 3'b100, s1);
      push(EV_RISE,  3'b000, s1 + 3);
      push(EV_GEND,  3'b000, s1 + 7);
      push(EV_DONE,  3'b000, s1 + 7);
      push(EV_IDLE,  3'b000, s1 + 10);
      drive_req(3'b101, 1);
      wait_until(s1 + 15);

      // Rest: half=0, dur=10 keeps buzzer low with grant held
      set_tone(0, 0, 10);
      k = cyc; s = k + 2;
      push(EV_GRANT, 3'b001, s);
      push(EV_GEND,  3'b000, s + 10);
      push(EV_DONE,  3'b000, s + 10);
      push(EV_IDLE,  3'b000, s + 13);
      drive_req(3'b001, 1);
      wait_until(s + 18);

      // dur=0: no grant, done pulses, gap still entered
      set_tone(1, 5, 0);
      k = cyc; s = k + 2;
      push(EV_DONE, 3'b000, s);
      push(EV_IDLE, 3'b000, s + 3);
      drive_req(3'b010, 1);
      wait_until(s + 8);

      // Re-request of req[2] in the cycle its grant clears pend
      set_tone(2, 2, 4);
      k = cyc; s = k + 2;
      push(EV_GRANT, 3'b100, s);
      push(EV_RISE,  3'b000, s + 2);
      push(EV_GEND,  3'b000, s + 4);
      push(EV_DONE,  3'b000, s + 4);
      push(EV_GRANT, 3'b100, s + 7);
      push(EV_RISE,  3'b000, s + 9);
      push(EV_GEND,  3'b000, s + 11);
      push(EV_DONE,  3'b000, s + 11);
      push(EV_IDLE,  3'b000, s + 14);
      drive_req(3'b100, 2);
      wait_until(s + 20);

      // req[0] arrives while a req[2] tone is playing
      set_tone(2, 3, 30);
      set_tone(0, 2, 4);
      k = cyc; s = k + 2;
      push(EV_GRANT, 3'b100, s);
      push(EV_RISE,  3'b000, s + 3);
`ifdef BUZZER_PREEMPT_EN
      push(EV_GRANT, 3'b001, s + 7);
      push(EV_RISE,  3'b000, s + 9);
      push(EV_GEND,  3'b000, s + 11);
      push(EV_DONE,  3'b000, s + 11);
      push(EV_IDLE,  3'b000, s + 14);
`else
      push(EV_RISE,  3'b000, s + 9);
      push(EV_RISE,  3'b000, s + 15);
      push(EV_RISE,  3'b000, s + 21);
      push(EV_RISE,  3'b000, s + 27);
      push(EV_GEND,  3'b000, s + 30);
      push(EV_DONE,  3'b000, s + 30);
      push(EV_GRANT, 3'b001, s + 33);
      push(EV_RISE,  3'b000, s + 35);
      push(EV_GEND,  3'b000, s + 37);
      push(EV_DONE,  3'b000, s + 37);
      push(EV_IDLE,  3'b000, s + 40);
`endif
      drive_req(3'b100, 1);
      wait_until(s + 5);
      drive_req(3'b001, 1);
      wait_until(s + 50);

      // Every expected event must have been seen within the bound
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
      n_total++;
      if (exp_q.size() == 0) begin
         n_pass++;
         $display("ok   all expected events observed");
      end else begin
         $display("FAIL missing_events: got %0d still pending, required 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
